// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings driven
// on ui_in[2:0].
package univ_shift_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 3'b000,
    MODE_SHL    = 3'b001,
    MODE_SHR    = 3'b010,
    MODE_ROL    = 3'b011,
    MODE_ROR    = 3'b100,
    MODE_LOAD   = 3'b101,
    MODE_TOGGLE = 3'b110,
    MODE_ASR    = 3'b111
  } shift_mode_e;

endpackage

// File: rtl/univ_shift_if.sv
// Control/data bundle between the pin wrapper (master) and the shift core (slave).
interface univ_shift_if
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  shift_mode_e      mode;
  logic             sir;
  logic             sil;
  logic             sen;
  logic             sclr;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output mode, sir, sil, sen, sclr, d, input q);
  modport slave  (input mode, sir, sil, sen, sclr, d, output q);

endinterface

// File: rtl/univ_shift_core.sv
// Parametrised universal shift register datapath; holds the single WIDTH-bit
// register of the design.
module univ_shift_core
  import univ_shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  univ_shift_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;

  // Clear beats enable, enable beats mode; serial inputs only reach SHL/SHR.
  always_comb begin
    q_nxt = q;
    if (bus.sclr) begin
      q_nxt = RESET_VAL;
    end else if (bus.sen) begin
      unique case (bus.mode)
        MODE_HOLD:   q_nxt = q;
        MODE_SHL:    q_nxt = {q[WIDTH-2:0], bus.sir};
        MODE_SHR:    q_nxt = {bus.sil, q[WIDTH-1:1]};
        MODE_ROL:    q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROR:    q_nxt = {q[0], q[WIDTH-1:1]};
        MODE_LOAD:   q_nxt = bus.d;
        MODE_TOGGLE: q_nxt = ~q;
        MODE_ASR:    q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else begin
      q <= q_nxt;
    end
  end

  assign bus.q = q;

endmodule

// File: rtl/tt_um_ay5876_univ_shift_reg.sv
// Pin wrapper: maps the ui/uio/uo pins onto the shift core; no logic of its own.
module tt_um_ay5876_univ_shift_reg
  import univ_shift_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int WIDTH = 8;

  univ_shift_if #(.WIDTH(WIDTH)) core_bus ();

  assign core_bus.mode = shift_mode_e'(ui_in[2:0]);
  assign core_bus.sir  = ui_in[3];
  assign core_bus.sil  = ui_in[4];
  assign core_bus.sen  = ui_in[5];
  assign core_bus.sclr = ui_in[6];
  assign core_bus.d    = uio_in;

  univ_shift_core #(
    .WIDTH     (WIDTH),
    .RESET_VAL (8'h00)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (core_bus.slave)
  );

  assign uo_out  = core_bus.q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // ena and ui_in[7] are deliberately ignored.
  logic unused_pins;
  assign unused_pins = &{ena, ui_in[7], 1'b0};

endmodule

// File: tb/tb_tt_um_ay5876_univ_shift_reg.sv
// Directed bench for the universal shift register with an arithmetic model
// compared against uo_out on every falling clock edge.
module tb_tt_um_ay5876_univ_shift_reg;
  import univ_shift_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       bit7;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  logic       chk_en = 1'b0;
  logic [7:0] m = 8'h00;

  univ_shift_if #(.WIDTH(8)) tb_bus ();

  assign ui_in    = {bit7, tb_bus.sclr, tb_bus.sen, tb_bus.sil, tb_bus.sir, tb_bus.mode};
  assign uio_in   = tb_bus.d;
  assign tb_bus.q = uo_out;

  tt_um_ay5876_univ_shift_reg dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next register value from plain integer arithmetic on the 8-bit value.
  function automatic logic [7:0] model_next(input logic [7:0] q, input logic [2:0] md,
                                            input logic sr, input logic sl, input logic en,
                                            input logic cl, input logic [7:0] dd);
    int v;
    int qi;
    qi = int'(q);
    if (cl) return 8'h00;
    if (!en) return q;
    case (md)
      3'd1:    v = (qi * 2 + int'(sr)) % 256;
      3'd2:    v = qi / 2 + int'(sl) * 128;
      3'd3:    v = (qi * 2) % 256 + qi / 128;
      3'd4:    v = qi / 2 + (qi % 2) * 128;
      3'd5:    v = int'(dd);
      3'd6:    v = 255 - qi;
      3'd7:    v = qi / 2 + (qi / 128) * 128;
      default: v = qi;
    endcase
    return v[7:0];
  endfunction

  always @(negedge rst_n) m = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) m = 8'h00;
    else m = model_next(m, ui_in[2:0], ui_in[3], ui_in[4], ui_in[5], ui_in[6], uio_in);
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("q_vs_model", uo_out, m);
      check("uio_out_tied", uio_out, 8'h00);
      check("uio_oe_tied", uio_oe, 8'h00);
    end
  end

  // Drive one input vector, let n rising edges pass, return just after the next falling edge.
  task automatic apply(input logic [2:0] md, input logic sr, input logic sl, input logic en,
                       input logic cl, input logic [7:0] dd, input int n);
    tb_bus.mode = shift_mode_e'(md);
    tb_bus.sir  = sr;
    tb_bus.sil  = sl;
    tb_bus.sen  = en;
    tb_bus.sclr = cl;
    tb_bus.d    = dd;
    bit7        = ~bit7;
    ena         = ~ena;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [7:0] exp);
    check(nm, uo_out, exp);
    check({nm, "_model"}, m, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    bit7  = 1'b0;
    tb_bus.mode = MODE_HOLD;
    tb_bus.sir  = 1'b0;
    tb_bus.sil  = 1'b0;
    tb_bus.sen  = 1'b0;
    tb_bus.sclr = 1'b0;
    tb_bus.d    = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_value", uo_out, 8'h00);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Asynchronous reset between edges, then held through edges with a load pending.
    apply(3'b101, 0, 0, 1, 0, 8'h5A, 1);  lit("load_5a", 8'h5A);
    rst_n = 1'b0;
    #1;
    lit("async_reset_now", 8'h00);
    apply(3'b101, 0, 0, 1, 0, 8'hFF, 3);  lit("reset_held", 8'h00);
    rst_n = 1'b1;
    apply(3'b101, 0, 0, 1, 0, 8'hFF, 1);  lit("first_edge_after_reset", 8'hFF);

    apply(3'b101, 0, 0, 1, 0, 8'hA5, 1);  lit("load_a5", 8'hA5);
    apply(3'b001, 1, 0, 1, 0, 8'h00, 1);  lit("shl_sir1", 8'h4B);
    apply(3'b010, 0, 0, 1, 0, 8'h00, 1);  lit("shr_sil0", 8'h25);
    apply(3'b010, 0, 1, 1, 0, 8'h00, 1);  lit("shr_sil1", 8'h92);

    apply(3'b101, 0, 0, 1, 0, 8'h81, 1);  lit("load_81", 8'h81);
    apply(3'b011, 1, 1, 1, 0, 8'h00, 1);  lit("rol_1", 8'h03);
    apply(3'b100, 1, 1, 1, 0, 8'h00, 2);  lit("ror_2", 8'hC0);
    apply(3'b101, 0, 0, 1, 0, 8'h81, 1);
    apply(3'b011, 0, 0, 1, 0, 8'h00, 8);  lit("rol_8", 8'h81);

    apply(3'b101, 0, 0, 1, 0, 8'h90, 1);  lit("load_90", 8'h90);
    apply(3'b111, 0, 0, 1, 0, 8'h00, 1);  lit("asr", 8'hC8);
    apply(3'b110, 1, 1, 1, 0, 8'h00, 1);  lit("toggle", 8'h37);
    apply(3'b101, 0, 0, 1, 0, 8'h10, 1);
    apply(3'b111, 1, 1, 1, 0, 8'h00, 1);  lit("asr_ignores_sil", 8'h08);
    apply(3'b000, 1, 1, 1, 0, 8'hFF, 2);  lit("mode_hold", 8'h08);

    // Inputs that change only between edges must leave no trace.
    tb_bus.mode = MODE_LOAD;
    tb_bus.d    = 8'hFF;
    #2;
    tb_bus.mode = MODE_HOLD;
    apply(3'b000, 0, 0, 1, 0, 8'h00, 1);  lit("between_edges", 8'h08);

    apply(3'b101, 0, 0, 1, 0, 8'h5A, 1);
    apply(3'b101, 0, 0, 1, 1, 8'hFF, 1);  lit("sclr_over_load", 8'h00);
    apply(3'b101, 0, 0, 1, 0, 8'h5A, 1);
    apply(3'b001, 1, 0, 0, 0, 8'h00, 2);  lit("sen0_holds", 8'h5A);
    apply(3'b001, 1, 0, 0, 1, 8'h00, 1);  lit("sclr_sen0", 8'h00);

    // Reset pulse in the middle of a shift-left run.
    apply(3'b101, 0, 0, 1, 0, 8'hC3, 1);
    apply(3'b001, 1, 0, 1, 0, 8'h00, 1);  lit("shl_before_pulse", 8'h87);
    rst_n = 1'b0;
    #1;
    lit("mid_shift_reset", 8'h00);
    #1;
    rst_n = 1'b1;
    apply(3'b001, 1, 0, 1, 0, 8'h00, 1);  lit("resume_after_pulse", 8'h01);
    apply(3'b001, 1, 0, 1, 0, 8'h00, 2);  lit("resume_more", 8'h07);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_ay5876_univ_shift_reg.md
TT_UM_AY5876_UNIV_SHIFT_REG -- requirements
Module: tt_um_ay5876_univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; the top-level pin mapping SHALL use WIDTH=8.
REQ-002 Parameter RESET_VAL, default 8'h00: register value applied on reset, WIDTH bits.
REQ-003 clk  in  1: single clock; all state SHALL update on the rising edge only.
REQ-004 rst_n  in  1: reset, asynchronous and active-low.
REQ-005 ui_in  in  8: [2:0] mode, [3] serial-in right (sir), [4] serial-in left (sil), [5] shift enable (sen), [6] synchronous clear (sclr), [7] unused.
REQ-006 uio_in  in  8: parallel load data D[7:0].
REQ-007 uo_out  out  8: register contents Q[7:0].
REQ-008 uio_out  out  8: SHALL be tied to 8'h00.
REQ-009 uio_oe  out  8: SHALL be tied to 8'h00; all uio pins are inputs.
REQ-010 ena  in  1: SHALL be ignored, along with ui_in[7].

Function
REQ-011 Q SHALL be registered; uo_out SHALL equal Q with no combinational path from any input.
REQ-012 Priority per clk edge: sclr=1 SHALL load RESET_VAL regardless of sen or mode; otherwise sen=0 SHALL hold Q; otherwise mode SHALL apply.
REQ-013 Mode 000 hold: Q unchanged.
REQ-014 Mode 001 shift left: Q <= {Q[W-2:0], sir}.
REQ-015 Mode 010 logical shift right: Q <= {sil, Q[W-1:1]}.
REQ-016 Mode 011 rotate left: Q <= {Q[W-2:0], Q[W-1]}.
REQ-017 Mode 100 rotate right: Q <= {Q[0], Q[W-1:1]}.
REQ-018 Mode 101 parallel load: Q <= D; the loaded value SHALL be visible on uo_out one cycle after the sampling edge.
REQ-019 Mode 110 toggle: Q <= ~Q (all bits act as T flip-flops).
REQ-020 Mode 111 arithmetic shift right: Q <= {Q[W-1], Q[W-1:1]}; sil SHALL be ignored.
REQ-021 Latency from sampled inputs to Q SHALL be exactly one clk cycle in every mode.
REQ-022 Serial inputs SHALL be consumed only in modes 001/010; in other modes they SHALL have no effect.
REQ-023 Bits shifted out of the register SHALL be discarded; there is no carry or serial-out flag.
REQ-024 Mode or input changes between edges SHALL have no effect; only values present at the edge count.

Reset
REQ-025 rst_n low SHALL force Q to RESET_VAL immediately, independent of clk.
REQ-026 While rst_n is low, Q SHALL stay at RESET_VAL regardless of clk or inputs.
REQ-027 After rst_n deasserts, the first rising clk edge SHALL act on the inputs normally.
REQ-028 Reset asserted mid-sequence SHALL abort the sequence; no partial shift state SHALL be retained.

Structure
REQ-029 Mode encodings (MODE_HOLD..MODE_ASR, 3 bits) SHALL be defined as named constants in a shared package, univ_shift_pkg.
REQ-030 The datapath SHALL be a parametrised sub-module univ_shift_core (WIDTH, RESET_VAL), instantiated by the top-level wrapper, which only maps pins.
REQ-031 univ_shift_core SHALL contain the only state element: one WIDTH-bit register.

Verification
REQ-032 Reset: rst_n=0 without clk -> Q=8'h00 immediately; mode 101, D=8'hFF with rst_n=0 held -> Q stays 8'h00.
REQ-033 Load/shift: load 8'hA5, then mode 001, sir=1, sen=1, 1 cycle -> Q=8'h4B; then mode 010, sil=0 -> Q=8'h25.
REQ-034 Rotate: load 8'h81; mode 011, 1 cycle -> 8'h03; mode 100, 2 cycles -> 8'hC0; 8 cycles of mode 011 from 8'h81 -> 8'h81.
REQ-035 ASR/toggle: load 8'h90; mode 111, sil=0, 1 cycle -> 8'hC8; mode 110, 1 cycle -> 8'h37.
REQ-036 Priority: Q=8'h5A, sclr=1 with mode 101, D=8'hFF -> Q=8'h00; sclr=0, sen=0, mode 001 -> Q holds.
REQ-037 Async reset mid-shift: rst_n pulsed low between edges during a mode-001 sequence -> Q=8'h00 at once; the next edge resumes shifting from 8'h00.
